fas_peak_detect: RTL and testbench

- Frequency-analysis stage directly downstream of the FIR/FFT datapath.
- Captures one 16-point FFT frame, i.e. the fft_d0..fft_d15 bus qualified by fft_valid.
- Computes the squared magnitude of each bin sequentially using a single shared multiplier pair.
- Reports the index of the strongest bin on freq, with a one-cycle done pulse.

---
 rtl/fas_peak_detect.sv | 174 +++++++++++++++++
 tb/tb_fas_peak_detect.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fas_peak_detect.sv
// Peak-bin detector: latches a 16-bin FFT frame, scans |X[k]|^2 with one shared
// multiplier pair and reports the strongest bin index. Option: FAS_PEAK_SKIP_DC_EN.
module fas_peak_detect #(
  parameter int unsigned DW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fft_valid,
  input  logic [2*DW-1:0]   fft_d0,
  input  logic [2*DW-1:0]   fft_d1,
  input  logic [2*DW-1:0]   fft_d2,
  input  logic [2*DW-1:0]   fft_d3,
  input  logic [2*DW-1:0]   fft_d4,
  input  logic [2*DW-1:0]   fft_d5,
  input  logic [2*DW-1:0]   fft_d6,
  input  logic [2*DW-1:0]   fft_d7,
  input  logic [2*DW-1:0]   fft_d8,
  input  logic [2*DW-1:0]   fft_d9,
  input  logic [2*DW-1:0]   fft_d10,
  input  logic [2*DW-1:0]   fft_d11,
  input  logic [2*DW-1:0]   fft_d12,
  input  logic [2*DW-1:0]   fft_d13,
  input  logic [2*DW-1:0]   fft_d14,
  input  logic [2*DW-1:0]   fft_d15,
  output logic              busy,
  output logic              done,
  output logic [3:0]        freq
);

  localparam int unsigned NBIN = 16;
  localparam int unsigned CW   = 4;
  localparam int unsigned WW   = 2 * DW;
  localparam int unsigned MW   = 2 * DW + 1;

`ifdef FAS_PEAK_SKIP_DC_EN
  localparam logic [CW-1:0] IDX_INIT = CW'(1);
`else
  localparam logic [CW-1:0] IDX_INIT = '0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic              load_c;
  logic [WW-1:0]     din   [NBIN];
  logic [WW-1:0]     frame_q [NBIN];
  logic [CW-1:0]     cnt_q;
  logic [MW-1:0]     mag_q;
  logic              cmp_en_q;
  logic [CW-1:0]     cmp_idx_q;
  logic [MW-1:0]     max_q;
  logic [CW-1:0]     idx_q;
  logic              busy_q;
  logic              done_q;
  logic [CW-1:0]     freq_q;

  assign din[0]  = fft_d0;
  assign din[1]  = fft_d1;
  assign din[2]  = fft_d2;
  assign din[3]  = fft_d3;
  assign din[4]  = fft_d4;
  assign din[5]  = fft_d5;
  assign din[6]  = fft_d6;
  assign din[7]  = fft_d7;
  assign din[8]  = fft_d8;
  assign din[9]  = fft_d9;
  assign din[10] = fft_d10;
  assign din[11] = fft_d11;
  assign din[12] = fft_d12;
  assign din[13] = fft_d13;
  assign din[14] = fft_d14;
  assign din[15] = fft_d15;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state and frame-load strobe
  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (fft_valid) begin
          load_c  = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (cnt_q == CW'(NBIN - 1)) state_d = DONE;
      end
      DONE: begin
        if (fft_valid) begin
          load_c  = 1'b1;
          state_d = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Magnitude of the current bin; products of 16-bit signed values are exact in 32 bits
  logic [WW-1:0]        word_c;
  logic signed [DW-1:0] re_c, im_c;
  logic signed [WW-1:0] re_sq_c, im_sq_c;
  logic [MW-1:0]        mag_c;

  assign word_c  = frame_q[cnt_q];
  assign re_c    = word_c[WW-1:DW];
  assign im_c    = word_c[DW-1:0];
  assign re_sq_c = WW'(re_c) * WW'(re_c);
  assign im_sq_c = WW'(im_c) * WW'(im_c);
  assign mag_c   = MW'($unsigned(re_sq_c)) + MW'($unsigned(im_sq_c));

  // Compare stage runs one cycle behind the multiply; strict > keeps the lowest index on ties
  logic          upd_c;
  logic [CW-1:0] best_idx_c;

`ifdef FAS_PEAK_SKIP_DC_EN
  assign upd_c = cmp_en_q && (cmp_idx_q != '0) && (mag_q > max_q);
`else
  assign upd_c = cmp_en_q && (mag_q > max_q);
`endif
  assign best_idx_c = upd_c ? cmp_idx_q : idx_q;

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NBIN; k++) frame_q[k] <= '0;
      cnt_q     <= '0;
      mag_q     <= '0;
      cmp_en_q  <= 1'b0;
      cmp_idx_q <= '0;
      max_q     <= '0;
      idx_q     <= IDX_INIT;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      freq_q    <= '0;
    end else begin
      busy_q    <= (state_q == SCAN);
      done_q    <= (state_q == DONE);
      cmp_en_q  <= (state_q == SCAN);
      cmp_idx_q <= cnt_q;
      if (state_q == SCAN) begin
        mag_q <= mag_c;
        cnt_q <= cnt_q + CW'(1);
      end
      if (upd_c) begin
        max_q <= mag_q;
        idx_q <= cmp_idx_q;
      end
      if (state_q == DONE) freq_q <= best_idx_c;
      if (load_c) begin
        for (int k = 0; k < NBIN; k++) frame_q[k] <= din[k];
        cnt_q <= '0;
        max_q <= '0;
        idx_q <= IDX_INIT;
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign freq = freq_q;

endmodule

// File: tb/tb_fas_peak_detect.sv
// Scoreboard bench for fas_peak_detect: a frame-level model predicts which
// strobes are accepted, when done fires and which bin wins.
module tb_fas_peak_detect;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fft_valid = 1'b0;
  logic [31:0] d [16];
  logic        busy, done;
  logic [3:0]  freq;

  fas_peak_detect #(.DW(16)) dut (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(d[0]),   .fft_d1(d[1]),   .fft_d2(d[2]),   .fft_d3(d[3]),
    .fft_d4(d[4]),   .fft_d5(d[5]),   .fft_d6(d[6]),   .fft_d7(d[7]),
    .fft_d8(d[8]),   .fft_d9(d[9]),   .fft_d10(d[10]), .fft_d11(d[11]),
    .fft_d12(d[12]), .fft_d13(d[13]), .fft_d14(d[14]), .fft_d15(d[15]),
    .busy(busy), .done(done), .freq(freq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_chk = 0;
  int          n_fail = 0;
  int          last_acc = -100;
  int          exp_cyc [$];
  logic [3:0]  exp_f [$];
  logic [3:0]  hold = 4'd0;
  logic [31:0] stim [16];

  task automatic chk(input string nm, input longint act, input longint expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, expv, cyc);
    end
  endtask

  // Reference: argmax of re^2+im^2 over the frame, strict >, lowest index on ties
  function automatic logic [3:0] ref_peak();
    longint     mx = 0;
    int         start;
    logic [3:0] bi;
`ifdef FAS_PEAK_SKIP_DC_EN
    start = 1;
`else
    start = 0;
`endif
    bi = 4'(start);
    for (int k = start; k < 16; k++) begin
      shortint re, im;
      longint  m;
      re = shortint'(stim[k][31:16]);
      im = shortint'(stim[k][15:0]);
      m  = longint'(re) * longint'(re) + longint'(im) * longint'(im);
      if (m > mx) begin
        mx = m;
        bi = 4'(k);
      end
    end
    return bi;
  endfunction

  // Called at a negedge; strobe is sampled at the next rising edge
  task automatic send();
    int t;
    t = cyc + 1;
    for (int k = 0; k < 16; k++) d[k] = stim[k];
    fft_valid = 1'b1;
    if (rst === 1'b1 && (t - last_acc >= 17)) begin
      last_acc = t;
      exp_cyc.push_back(t + 17);
      exp_f.push_back(ref_peak());
    end
    @(negedge clk);
    fft_valid = 1'b0;
    for (int k = 0; k < 16; k++) d[k] = $urandom;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    exp_cyc.delete();
    exp_f.delete();
    last_acc = -100;
    hold = 4'd0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_freq", freq, 0);
    repeat (n) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic clear_stim();
    for (int k = 0; k < 16; k++) stim[k] = 32'h0;
  endtask

  // Monitor: every cycle compare done/busy/freq against the scoreboard
  initial begin
    logic exp_done, exp_busy;
    forever begin
      @(posedge clk);
      #1;
      exp_done = 1'b0;
      if (exp_cyc.size() > 0 && exp_cyc[0] == cyc) begin
        exp_done = 1'b1;
        hold = exp_f[0];
        void'(exp_cyc.pop_front());
        void'(exp_f.pop_front());
      end
      exp_busy = (rst === 1'b1) && (cyc - last_acc >= 1) && (cyc - last_acc <= 16);
      chk("done", done, exp_done);
      chk("busy", busy, exp_busy);
      chk("freq", freq, hold);
    end
  end

  initial begin
    for (int k = 0; k < 16; k++) d[k] = 32'h0;
    clear_stim();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle(50);

    // Single peak at bin 5, weaker bin 9
    clear_stim();
    stim[5] = {16'h0100, 16'h0000};
    stim[9] = {16'h0000, 16'h00C0};
    send();
    idle(20);

    // Tie of extreme values: lowest index wins
    for (int k = 0; k < 16; k++) stim[k] = {16'h7FFF, 16'h0000};
    stim[3]  = 32'h8000_8000;
    stim[12] = 32'h8000_8000;
    send();
    idle(20);

    // DC dominant, and an all-zero frame
    clear_stim();
    stim[0] = 32'h7FFF_7FFF;
    stim[6] = 32'h0010_0000;
    send();
    idle(20);
    clear_stim();
    send();
    idle(20);

    // Back-to-back frames with a dropped strobe during the first scan
    clear_stim();
    stim[14] = 32'h4000_0000;
    send();
    idle(4);
    clear_stim();
    stim[0] = 32'h7FFF_7FFF;
    send();
    idle(11);
    clear_stim();
    stim[2] = 32'h0000_2000;
    send();
    idle(20);

    // Input bus changes right after the strobe
    clear_stim();
    stim[7] = 32'h0300_0300;
    send();
    for (int k = 0; k < 16; k++) d[k] = 32'h0;
    d[1] = 32'h7FFF_7FFF;
    idle(20);

    // Reset in the middle of a scan, then a normal frame
    clear_stim();
    stim[9] = 32'h1000_1000;
    send();
    idle(7);
    do_reset(2);
    clear_stim();
    stim[11] = 32'h0000_8000;
    send();
    idle(20);

    // Randomised frames with random gaps (some back-to-back, some dropped)
    repeat (60) begin
      int mode;
      mode = int'($urandom_range(0, 3));
      for (int k = 0; k < 16; k++) begin
        int a, b;
        case (mode)
          0: stim[k] = $urandom;
          1: begin
            a = int'($urandom_range(0, 4)) - 2;
            b = int'($urandom_range(0, 4)) - 2;
            stim[k] = {16'(a), 16'(b)};
          end
          2: begin
            a = int'($urandom_range(0, 3));
            stim[k] = (a == 0) ? 32'h8000_0000 : (a == 1) ? 32'h7FFF_8001 : 32'h0;
          end
          default: stim[k] = 32'h0123_4567;
        endcase
      end
      send();
      idle(int'($urandom_range(0, 20)));
    end

    idle(25);
    chk("drain", exp_cyc.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
